// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl: push/pop FIFO controller driving an external dual-port RAM
// with a registered 1-cycle read port.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : enqueue request and data
//   pop               : dequeue request
//   pop_data          : RAM read data, qualified by pop_valid
//   pop_valid         : high the cycle after an accepted pop
//   full, empty       : occupancy flags (count == DEPTH / count == 0)
//   almost_full/empty : count >= AF_LEVEL / count <= AE_LEVEL
//   count             : occupancy 0..DEPTH
//   overflow          : 1-cycle pulse, push while full
//   underflow         : 1-cycle pulse, pop while empty
//   ram_wr_en/addr/data, ram_rd_addr, ram_rd_data : RAM side
module fifo_ram_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_count;
  logic            r_pop_valid;
  logic            r_overflow;
  logic            r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push_acc;
  logic w_pop_acc;

  // Flags come straight off the registered count.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Reset gates acceptance so no RAM write escapes during rst.
  assign w_push_acc = push & ~w_full  & ~rst;
  assign w_pop_acc  = pop  & ~w_empty & ~rst;

  assign ram_wr_en   = w_push_acc;
  assign ram_wr_addr = r_wr_ptr[ADDR_W-1:0];
  assign ram_wr_data = push_data;
  assign ram_rd_addr = r_rd_ptr[ADDR_W-1:0];

  assign pop_data     = ram_rd_data;
  assign pop_valid    = r_pop_valid;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (r_count <= CNT_W'(AE_LEVEL));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_pop_valid <= w_pop_acc;
      r_overflow  <= push & w_full;
      r_underflow <= pop & w_empty;
    end
  end

endmodule
